// File: rtl/midi_pkg.sv
// Shared constants and types for the MIDI note parser.
// Status nibbles, byte-class thresholds, FSM state encoding and default reset note.
package midi_pkg;

    localparam logic [3:0] NOTE_OFF = 4'h8;
    localparam logic [3:0] NOTE_ON  = 4'h9;
    localparam logic [3:0] PROG_CHG = 4'hC;
    localparam logic [3:0] CH_PRESS = 4'hD;

    localparam logic [7:0] RT_THRESHOLD  = 8'hF8;
    localparam logic [7:0] SYS_THRESHOLD = 8'hF0;

    localparam logic [7:0] RESET_NOTE_DFLT = 8'd69;

    typedef enum logic [1:0] {
        StIdle,
        StWaitD1,
        StWaitD2
    } parse_state_e;

    typedef enum logic [1:0] {
        ClsData,
        ClsVoice,
        ClsSystem,
        ClsRealtime
    } byte_class_e;

endpackage

// File: rtl/midi_status_decode.sv
// Combinational MIDI byte classifier: byte class, status data length, note-message acceptance.
// MIDI_PARSER_OMNI_EN defined: channel nibble ignored (all 16 channels accepted).
module midi_status_decode
    import midi_pkg::*;
#(
    parameter logic [3:0] CHANNEL = 4'd0
) (
    input  logic [7:0]  byte_i,
    output byte_class_e class_o,
    output logic        one_data_o,
    output logic        note_msg_o,
    output logic        note_on_o
);

    logic chan_match;

`ifdef MIDI_PARSER_OMNI_EN
    assign chan_match = 1'b1;
`else
    assign chan_match = (byte_i[3:0] == CHANNEL);
`endif

    always_comb begin
        class_o = ClsData;
        if (byte_i >= RT_THRESHOLD) begin
            class_o = ClsRealtime;
        end else if (byte_i >= SYS_THRESHOLD) begin
            class_o = ClsSystem;
        end else if (byte_i[7]) begin
            class_o = ClsVoice;
        end
    end

    assign one_data_o = (byte_i[7:4] == PROG_CHG) || (byte_i[7:4] == CH_PRESS);
    assign note_on_o  = (byte_i[7:4] == NOTE_ON);
    // Only note messages on an accepted channel ever touch the outputs.
    assign note_msg_o = chan_match && ((byte_i[7:4] == NOTE_OFF) || (byte_i[7:4] == NOTE_ON));

endmodule

// File: rtl/midi_note_parser.sv
// Monophonic MIDI note parser with running status and last-note priority.
// MIDI_PARSER_OMNI_EN defined: note messages on all channels accepted, CHANNEL unused.
module midi_note_parser
    import midi_pkg::*;
#(
    parameter logic [3:0] CHANNEL    = 4'd0,
    parameter logic [7:0] RESET_NOTE = RESET_NOTE_DFLT
) (
    input  logic       clk_i,
    input  logic       nrst_i,
    input  logic [7:0] byte_i,
    input  logic       byteValid_i,
    output logic [7:0] note_o,
    output logic [6:0] velocity_o,
    output logic       gate_o,
    output logic       noteStrobe_o
);

    byte_class_e byte_class;
    logic        one_data, note_msg, note_on;

    midi_status_decode #(
        .CHANNEL(CHANNEL)
    ) u_decode (
        .byte_i    (byte_i),
        .class_o   (byte_class),
        .one_data_o(one_data),
        .note_msg_o(note_msg),
        .note_on_o (note_on)
    );

    parse_state_e state_q;
    logic         run_note_msg_q, run_note_on_q, run_one_data_q;
    logic [6:0]   key_q;
    // Completed-message stage between the parser and the output registers.
    logic         evt_q, evt_on_q;
    logic [6:0]   evt_key_q, evt_vel_q;
    logic [7:0]   note_q;
    logic [6:0]   velocity_q;
    logic         gate_q, strobe_q;

    always_ff @(posedge clk_i or negedge nrst_i) begin
        if (!nrst_i) begin
            state_q        <= StIdle;
            run_note_msg_q <= 1'b0;
            run_note_on_q  <= 1'b0;
            run_one_data_q <= 1'b0;
            key_q          <= 7'd0;
            evt_q          <= 1'b0;
            evt_on_q       <= 1'b0;
            evt_key_q      <= 7'd0;
            evt_vel_q      <= 7'd0;
            note_q         <= RESET_NOTE;
            velocity_q     <= 7'd0;
            gate_q         <= 1'b0;
            strobe_q       <= 1'b0;
        end else begin
            evt_q    <= 1'b0;
            strobe_q <= 1'b0;

            if (byteValid_i) begin
                unique case (byte_class)
                    ClsRealtime: ;
                    ClsSystem: begin
                        state_q        <= StIdle;
                        run_note_msg_q <= 1'b0;
                    end
                    ClsVoice: begin
                        state_q        <= StWaitD1;
                        run_note_msg_q <= note_msg;
                        run_note_on_q  <= note_on;
                        run_one_data_q <= one_data;
                    end
                    ClsData: begin
                        unique case (state_q)
                            StIdle: ;
                            StWaitD1: begin
                                key_q   <= byte_i[6:0];
                                state_q <= run_one_data_q ? StWaitD1 : StWaitD2;
                            end
                            StWaitD2: begin
                                state_q   <= StWaitD1;
                                evt_q     <= run_note_msg_q;
                                evt_on_q  <= run_note_on_q && (byte_i[6:0] != 7'd0);
                                evt_key_q <= key_q;
                                evt_vel_q <= byte_i[6:0];
                            end
                            default: state_q <= StIdle;
                        endcase
                    end
                    default: ;
                endcase
            end

            if (evt_q) begin
                if (evt_on_q) begin
                    note_q     <= {1'b0, evt_key_q};
                    velocity_q <= evt_vel_q;
                    gate_q     <= 1'b1;
                    strobe_q   <= 1'b1;
                end else if (gate_q && (note_q[6:0] == evt_key_q)) begin
                    gate_q   <= 1'b0;
                    strobe_q <= 1'b1;
                end
            end
        end
    end

    assign note_o       = note_q;
    assign velocity_o   = velocity_q;
    assign gate_o       = gate_q;
    assign noteStrobe_o = strobe_q;

endmodule

// File: tb/tb_midi_note_parser.sv
// Scoreboard bench for midi_note_parser: directed cases plus random byte streams
// checked against a message-level MIDI reference model.
module tb_midi_note_parser;

    localparam int CH = 0;

    logic       clk = 1'b0;
    logic       nrst;
    logic [7:0] byte_d;
    logic       byte_valid;
    logic [7:0] note;
    logic [6:0] vel;
    logic       gate, strobe;

    always #5 clk = ~clk;

    midi_note_parser #(
        .CHANNEL   (4'(CH)),
        .RESET_NOTE(8'd69)
    ) dut (
        .clk_i       (clk),
        .nrst_i      (nrst),
        .byte_i      (byte_d),
        .byteValid_i (byte_valid),
        .note_o      (note),
        .velocity_o  (vel),
        .gate_o      (gate),
        .noteStrobe_o(strobe)
    );

    typedef struct {
        int note;
        int vel;
        int gate;
        int due;
    } exp_t;

    exp_t sb[$];
    int   n_cmp  = 0;
    int   n_fail = 0;
    int   cyc    = 0;

    // Reference model state: running status and the presented note.
    int m_status, m_have, m_key;
    int m_note, m_vel, m_gate;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_status = -1;
        m_have   = 0;
        m_key    = 0;
        m_note   = 69;
        m_vel    = 0;
        m_gate   = 0;
        sb.delete();
    endtask

    task automatic model_msg(input int st, input int key, input int v);
        int  typ;
        bit  acc;
        exp_t e;
        typ = st >> 4;
`ifdef MIDI_PARSER_OMNI_EN
        acc = 1'b1;
`else
        acc = ((st & 15) == CH);
`endif
        if (!acc) return;
        if (typ == 9 && v > 0) begin
            m_note = key; m_vel = v; m_gate = 1;
        end else if ((typ == 8 || typ == 9) && key == m_note && m_gate == 1) begin
            m_gate = 0;
        end else begin
            return;
        end
        e.note = m_note; e.vel = m_vel; e.gate = m_gate; e.due = cyc + 1;
        sb.push_back(e);
    endtask

    task automatic model_byte(input int b);
        int len;
        if (b >= 'hF8) return;
        if (b >= 'hF0) begin
            m_status = -1;
            return;
        end
        if (b >= 'h80) begin
            m_status = b;
            m_have   = 0;
            return;
        end
        if (m_status < 0) return;
        len = ((m_status >> 4) == 'hC || (m_status >> 4) == 'hD) ? 1 : 2;
        if (m_have == 0) begin
            m_key = b;
            if (len == 2) m_have = 1;
        end else begin
            m_have = 0;
            model_msg(m_status, m_key, b);
        end
    endtask

    // Called at #1 after a rising edge; leaves at the same phase.
    task automatic send(input int b);
        byte_d     = 8'(b);
        byte_valid = 1'b1;
        @(posedge clk);
        #1;
        byte_valid = 1'b0;
        model_byte(b);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        nrst = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        check("reset_note", note, 69);
        check("reset_velocity", vel, 0);
        check("reset_gate", gate, 0);
        check("reset_strobe", strobe, 0);
        nrst = 1'b1;
    endtask

    task automatic check_state(input string name);
        idle(4);
        check({name, "_pending"}, sb.size(), 0);
        check({name, "_note"}, note, m_note);
        check({name, "_velocity"}, vel, m_vel);
        check({name, "_gate"}, gate, m_gate);
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (nrst && strobe) begin
            if (sb.size() == 0) begin
                check("unexpected_strobe", 1, 0);
            end else begin
                e = sb.pop_front();
                check("strobe_cycle", cyc, e.due);
                check("strobe_note", note, e.note);
                check("strobe_velocity", vel, e.vel);
                check("strobe_gate", gate, e.gate);
            end
        end
    end

    initial begin
        int r, b;
        nrst       = 1'b0;
        byte_d     = 8'h00;
        byte_valid = 1'b0;
        model_reset();
        #12;
        do_reset();
        idle(3);
        check("idle_note", note, 69);
        check("idle_gate", gate, 0);

        send('h90); send('h3C); send('h64);
        check_state("note_on");
        check("note_on_const_note", note, 60);
        check("note_on_const_vel", vel, 100);
        check("note_on_const_gate", gate, 1);
        send('h80); send('h3C); send('h00);
        check_state("note_off");
        check("note_off_const_gate", gate, 0);
        check("note_off_const_note", note, 60);

        send('h90); send('h40); send('h50); send('h45); send('h00);
        check_state("running_status");

        send('h90); send('h3C); send('hF8); send('h7F);
        check_state("realtime_mid_msg");

        send('h91); send('h3C); send('h64);
        check_state("other_channel");
        send('hC0); send('h05); send('h3C); send('h90);
        check_state("prog_change");

        send('h90); send('hF0); send('h3C); send('h64);
        check_state("sysex_clears");

        do_reset();
        send('h90); send('h3C);
        do_reset();
        send('h64);
        check_state("reset_mid_msg");
        check("reset_mid_msg_note", note, 69);

        for (int i = 0; i < 3000; i++) begin
            r = $urandom_range(0, 99);
            if (r < 12) begin
                case ($urandom_range(0, 7))
                    0: b = 'h80;
                    1: b = 'h91;
                    2: b = 'hC0;
                    3: b = 'hD0;
                    4: b = 'hB0;
                    5: b = 'hE0;
                    default: b = 'h90;
                endcase
            end else if (r < 15) begin
                b = $urandom_range('hF8, 'hFF);
            end else if (r < 17) begin
                b = $urandom_range('hF0, 'hF7);
            end else if (r < 60) begin
                b = 'h3C + $urandom_range(0, 3);
            end else if (r < 70) begin
                b = 0;
            end else begin
                b = $urandom_range(0, 127);
            end
            send(b);
            if ($urandom_range(0, 99) < 20) idle($urandom_range(1, 3));
            if ($urandom_range(0, 999) < 3) do_reset();
        end
        check_state("random");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/midi_note_parser.md
# midi_note_parser

Monophonic MIDI message parser that sits directly upstream of the note-to-counter-period converter. Consumes the byte stream from the MIDI UART receiver, tracks status/running status, and presents the active note number, velocity and a gate. `note_o` drives the converter's note input; `gate_o` enables the tone oscillator downstream.

## Interface
- `CHANNEL`, 4'd0: MIDI channel accepted (0–15, i.e. MIDI channels 1–16).
- `RESET_NOTE`, 8'd69: note presented after reset (A4).
- `clk_i`  in  1  system clock.
- `nrst_i`  in  1  reset; one clock; reset is asynchronous and active-low.
- `byte_i`  in  8  received MIDI byte; sampled only when `byteValid_i`=1.
- `byteValid_i`  in  1  one-cycle strobe from UART receiver; any rate, back-to-back allowed.
- `note_o`  out  8  current note, bit 7 always 0.
- `velocity_o`  out  7  velocity of current note.
- `gate_o`  out  1  1 while a note is held.
- `noteStrobe_o`  out  1  one-cycle pulse when `note_o`/`gate_o` changes due to a message.

## Operation
- Byte classes: bit7=1 status, bit7=0 data. 0xF8–0xFF real-time: ignored entirely, no state change, mid-message safe. 0xF0–0xF7 system common/SysEx: clear running status, go IDLE, discard following data bytes.
- Channel voice status (0x80–0xEF): latch as running status; message length 2 data bytes except 0xC_/0xD_ (1 data byte). Status for other channel or types 0xA_, 0xB_, 0xC_, 0xD_, 0xE_: data bytes counted and discarded.
- FSM states: IDLE (no running status, data bytes dropped), WAIT_D1, WAIT_D2. Status byte → WAIT_D1. Data in WAIT_D1 → latch as key; 2-byte msg → WAIT_D2, 1-byte msg → back to WAIT_D1 (running status). Data in WAIT_D2 → message complete, → WAIT_D1.
- Status byte arriving in WAIT_D2 or WAIT_D1 aborts the partial message; new status takes effect.
- On completed Note On (0x9n, n=CHANNEL) with velocity>0: `note_o`=key, `velocity_o`=vel, `gate_o`=1, strobe. Last-note priority: new note-on replaces held note.
- Note Off (0x8n) or Note On vel=0: if key == `note_o` and gate=1 → `gate_o`=0, strobe; `note_o`/`velocity_o` hold. Non-matching key: no effect, no strobe.
- Reset: `note_o`=RESET_NOTE, `velocity_o`=0, `gate_o`=0, `noteStrobe_o`=0, FSM IDLE, running status cleared. Reset mid-message discards it.

## Timing
- All outputs registered. Completing data byte sampled at edge k → outputs and strobe valid after edge k+1 (latency 1 cycle); strobe high exactly one cycle.
- Back-to-back `byteValid_i` every cycle supported, no stall, no ready signal; no byte lost.
- Two completed messages on consecutive bytes produce two separate strobes.

## Configuration
- `MIDI_PARSER_OMNI_EN` defined: channel nibble ignored, note messages on all 16 channels accepted; `CHANNEL` unused.
- Undefined: only channel `CHANNEL` accepted; others counted and discarded as above.

## Structure
- Shared package/header `midi_pkg`: status nibble constants (NOTE_OFF 4'h8, NOTE_ON 4'h9, PROG_CHG 4'hC, CH_PRESS 4'hD), real-time threshold 8'hF8, FSM state encoding, RESET_NOTE default.
- One sub-module natural: `midi_status_decode` (combinational: classify byte, data-length of status, channel match).

## Test plan
- Reset, no input → `note_o`=69, `gate_o`=0, `velocity_o`=0, no strobe.
- 0x90 0x3C 0x64 → 1 cycle after last byte `note_o`=60, `velocity_o`=100, `gate_o`=1, one strobe; then 0x80 0x3C 0x00 → `gate_o`=0, `note_o`=60.
- Running status: 0x90 0x40 0x50 0x45 0x00 → note 64 on, then note 69 vel 0 → no gate change (mismatch), single strobe total.
- 0x90 0x3C 0xF8 0x7F → real-time ignored, note 60 vel 127 on.
- 0x91 0x3C 0x64 → ignored unless `MIDI_PARSER_OMNI_EN`, then note 60 on; 0xC0 0x05 0x3C then 0x90 → no note change from program-change data.
- 0x90 0x3C, `nrst_i` low mid-message, release, 0x64 → dropped (IDLE), outputs at reset values.
